cond_flag_unit: RTL

// - Consumer side of the ALU flag interface. Holds the architectural NZCV register, evaluates each

---
 rtl/cond_flag_unit_if.sv | 34 +++
 rtl/cond_flag_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cond_flag_unit_if.sv
// Handshake and bus signals between the ALU side, cond_flag_unit and writeback.
// The slave modport is the cond_flag_unit view; master is the driver/consumer view.
interface cond_flag_unit_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [1:0]       flag_write;
    logic [3:0]       alu_flags;
    logic             reg_write_in;
    logic             mem_write_in;
    logic             pc_src_in;
    logic             out_valid;
    logic             out_ready;
    logic             cond_ex;
    logic             reg_write;
    logic             mem_write;
    logic             pc_src;
    logic [3:0]       flags;
    logic [CNT_W-1:0] squash_count;

    modport slave (
        input  in_valid, cond, flag_write, alu_flags, reg_write_in, mem_write_in, pc_src_in,
        input  out_ready,
        output in_ready, out_valid, cond_ex, reg_write, mem_write, pc_src, flags, squash_count
    );

    modport master (
        output in_valid, cond, flag_write, alu_flags, reg_write_in, mem_write_in, pc_src_in,
        output out_ready,
        input  in_ready, out_valid, cond_ex, reg_write, mem_write, pc_src, flags, squash_count
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Registered stage holding the NZCV register, evaluating ARM condition codes and gating writes.
// Define COND_SQUASH_CNT_EN to build the saturating squashed-instruction counter.
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input logic            clk,
    input logic            reset,
    cond_flag_unit_if.slave bus
);
    logic       in_ready;
    logic       accept;
    logic       cond_pass;
    logic       flag_n, flag_z, flag_c, flag_v;

    logic       out_valid_q, out_valid_d;
    logic       cond_ex_q, cond_ex_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic       pc_src_q, pc_src_d;
    logic [3:0] flags_q, flags_d;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition is judged against the register value before this instruction's own update.
    always_comb begin
        cond_pass = 1'b0;
        case (bus.cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        cond_ex_d   = cond_ex_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        pc_src_d    = pc_src_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            cond_ex_d   = cond_pass;
            reg_write_d = bus.reg_write_in & cond_pass;
            mem_write_d = bus.mem_write_in & cond_pass;
            pc_src_d    = bus.pc_src_in & cond_pass;
            if (cond_pass && bus.flag_write[1]) flags_d[3:2] = bus.alu_flags[3:2];
            if (cond_pass && bus.flag_write[0]) flags_d[1:0] = bus.alu_flags[1:0];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            out_valid_q <= out_valid_d;
            cond_ex_q   <= cond_ex_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
            flags_q     <= flags_d;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_count_q, squash_count_d;

    // Saturates at all-ones so a long run of squashes never wraps back to a small count.
    always_comb begin
        squash_count_d = squash_count_q;
        if (accept && !cond_pass && (squash_count_q != {CNT_W{1'b1}})) begin
            squash_count_d = squash_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_count_q <= {CNT_W{1'b0}};
        end else begin
            squash_count_q <= squash_count_d;
        end
    end

    assign bus.squash_count = squash_count_q;
`else
    assign bus.squash_count = {CNT_W{1'b0}};
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.cond_ex   = cond_ex_q;
    assign bus.reg_write = reg_write_q;
    assign bus.mem_write = mem_write_q;
    assign bus.pc_src    = pc_src_q;
    assign bus.flags     = flags_q;
endmodule
